// File: rtl/bnn_pkg.sv
// Shared definitions for the binarized-neuron blocks: the controller state
// encoding and the default word geometry.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BNN_WIDTH  = 16;
  localparam int BNN_NWORDS = 4;

endpackage

// File: rtl/bnn_popcount.sv
// Combinational population count built as a balanced binary adder tree.
// The input is zero-padded to a power of two so every tree level is full.
module bnn_popcount #(
  parameter  int WIDTH = 16,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] count_o
);

  localparam int LEAVES = 1 << $clog2(WIDTH);

  logic [LEAVES-1:0] padded;
  // Heap-ordered tree: node i has children 2i+1 and 2i+2, leaves at the tail.
  logic [OUT_W-1:0]  node [2*LEAVES-1];

  // Sum pairs of nodes bottom-up; no subtree can exceed WIDTH, so OUT_W bits suffice.
  always_comb begin
    // NOTE: every variable assigned in this block gets a value on every path before it is read; otherwise a latch is inferred.
    padded              = '0;
    padded[WIDTH-1:0]   = bits_i;
    for (int i = 0; i < LEAVES; i++) begin
      node[LEAVES-1+i] = OUT_W'(padded[i]);
    end
    for (int i = LEAVES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    count_o = node[0];
  end

endmodule

// File: rtl/xnor_popcount_neuron.sv
// Binarized neuron: accumulates popcount(XNOR(activation, weight)) over
// NWORDS word pairs, then presents the sum and a thresholded output bit.
// Optional build macro POPCOUNT_PIPE_EN registers the popcount before the
// accumulator adder, adding one cycle of latency to the result.
module xnor_popcount_neuron
  import bnn_pkg::*;
#(
  parameter int WIDTH  = BNN_WIDTH,
  parameter int NWORDS = BNN_NWORDS,
  parameter int ACC_W  = $clog2(WIDTH * NWORDS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_ACT,
  input  logic [WIDTH-1:0] IN_W,
  input  logic [ACC_W-1:0] THRESH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [ACC_W-1:0] OUT_SUM,
  output logic             OUT_BIT,
  output logic             BUSY
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc;
  logic             accept;
  logic             last_word;

`ifdef POPCOUNT_PIPE_EN
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             pc_vld_q, pc_vld_d;
  // Set once the final word is staged; blocks further words while it drains.
  logic             drain_q, drain_d;
`endif

  bnn_popcount #(.WIDTH(WIDTH)) u_popcount (
    .bits_i  (~(IN_ACT ^ IN_W)),
    .count_o (pc)
  );

  assign accept    = IN_READY && IN_VALID;
  assign last_word = (cnt_q == CNT_W'(NWORDS - 1));

  // State and datapath registers, cleared asynchronously by RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      thresh_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q  <= state_d;
      acc_q    <= acc_d;
      thresh_q <= thresh_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef POPCOUNT_PIPE_EN
  // Popcount stage register between the XNOR-popcount and the adder.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q     <= '0;
      pc_vld_q <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pc_vld_q <= pc_vld_d;
      drain_q  <= drain_d;
    end
  end
`endif

  // Next-state and datapath update; START is only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    thresh_d = thresh_q;
    cnt_d    = cnt_q;
`ifdef POPCOUNT_PIPE_EN
    pc_d     = pc_q;
    pc_vld_d = 1'b0;
    drain_d  = drain_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          acc_d    = '0;
          cnt_d    = '0;
          thresh_d = THRESH;
          state_d  = ST_ACCUM;
`ifdef POPCOUNT_PIPE_EN
          drain_d  = 1'b0;
`endif
        end
      end
      ST_ACCUM: begin
`ifdef POPCOUNT_PIPE_EN
        if (pc_vld_q) acc_d = acc_q + ACC_W'(pc_q);
        if (accept) begin
          pc_d     = pc;
          pc_vld_d = 1'b1;
          if (last_word) begin
            cnt_d   = '0;
            drain_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // The last staged popcount is added on this edge, so the sum is final in DONE.
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = ST_DONE;
        end
`else
        if (accept) begin
          acc_d = acc_q + ACC_W'(pc);
          if (last_word) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      ST_DONE: begin
        if (OUT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and result outputs decoded from the registered state.
  always_comb begin
`ifdef POPCOUNT_PIPE_EN
    IN_READY  = (state_q == ST_ACCUM) && !drain_q;
`else
    IN_READY  = (state_q == ST_ACCUM);
`endif
    OUT_VALID = (state_q == ST_DONE);
    BUSY      = (state_q != ST_IDLE);
    OUT_SUM   = acc_q;
    // Qualified by DONE so a cleared sum and threshold (0 >= 0) never reads as a firing neuron.
    OUT_BIT   = (state_q == ST_DONE) && (acc_q >= thresh_q);
  end

endmodule

// File: tb/tb_xnor_popcount_neuron.sv
// Self-checking bench for xnor_popcount_neuron with a result scoreboard.
// Honours POPCOUNT_PIPE_EN for the expected result latency.
module tb_xnor_popcount_neuron;

  localparam int WIDTH  = 16;
  localparam int NWORDS = 4;
  localparam int ACC_W  = 7;
`ifdef POPCOUNT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_ACT;
  logic [WIDTH-1:0] IN_W;
  logic [ACC_W-1:0] THRESH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [ACC_W-1:0] OUT_SUM;
  logic             OUT_BIT;
  logic             BUSY;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             bt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  xnor_popcount_neuron #(.WIDTH(WIDTH), .NWORDS(NWORDS), .ACC_W(ACC_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_ACT    (IN_ACT),
    .IN_W      (IN_W),
    .THRESH    (THRESH),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_SUM   (OUT_SUM),
    .OUT_BIT   (OUT_BIT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_sum(input logic [NWORDS*WIDTH-1:0] acts, input logic [NWORDS*WIDTH-1:0] ws);
    int s = 0;
    for (int i = 0; i < NWORDS; i++) begin
      s += $countones(~(acts[i*WIDTH +: WIDTH] ^ ws[i*WIDTH +: WIDTH]));
    end
    return s;
  endfunction

  // Present one word pair and wait (bounded) until it is accepted.
  task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] w);
    int n = 0;
    IN_ACT   = a;
    IN_W     = w;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("in_ready", IN_READY, 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic run_txn(input logic [ACC_W-1:0] thr,
                         input logic [NWORDS*WIDTH-1:0] acts,
                         input logic [NWORDS*WIDTH-1:0] ws,
                         input int gap, input int stall, input bit poke_start);
    exp_t             e;
    int               s;
    int               cyc;
    logic [ACC_W-1:0] held_sum;
    s     = model_sum(acts, ws);
    e.sum = ACC_W'(s);
    e.bt  = (s >= int'(thr));
    sb.push_back(e);

    START  = 1'b1;
    THRESH = thr;
    @(negedge CLK);
    START  = 1'b0;
    check("busy_after_start", BUSY, 1);

    for (int i = 0; i < NWORDS; i++) begin
      if (poke_start && i == 2) begin
        START  = 1'b1;
        THRESH = '0;
        @(negedge CLK);
        START  = 1'b0;
        THRESH = thr;
      end
      send_word(acts[i*WIDTH +: WIDTH], ws[i*WIDTH +: WIDTH]);
      if (i != NWORDS - 1) repeat (gap) @(negedge CLK);
    end

    cyc = 1;
    while (!OUT_VALID && cyc < 8) begin
      @(negedge CLK);
      cyc++;
    end
    check("latency", cyc, LAT);

    held_sum = OUT_SUM;
    for (int j = 0; j < stall; j++) begin
      if (poke_start && j == 0) begin
        START  = 1'b1;
        THRESH = '0;
      end
      @(negedge CLK);
      START  = 1'b0;
      THRESH = thr;
      check("stall_valid", OUT_VALID, 1);
      check("stall_sum", OUT_SUM, held_sum);
    end

    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("out_sum", OUT_SUM, e.sum);
      check("out_bit", OUT_BIT, e.bt);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("valid_drop", OUT_VALID, 0);
    check("idle_after", BUSY, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NWORDS*WIDTH-1:0] ones, a_alt, w_alt;
    bit seen;
    RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_ACT = '0; IN_W = '0;
    THRESH = '0; OUT_READY = 1'b0;
    #1;
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_sum", OUT_SUM, 0);
    check("rst_out_bit", OUT_BIT, 0);
    check("rst_busy", BUSY, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    ones  = {NWORDS{16'hFFFF}};
    a_alt = {16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA};
    w_alt = {NWORDS{16'hAAAA}};

    run_txn(7'd32, ones, ones, 0, 0, 1'b0);
    run_txn(7'd1, {NWORDS{16'h0F0F}}, {NWORDS{16'hF0F0}}, 0, 0, 1'b0);
    run_txn(7'd32, a_alt, w_alt, 0, 0, 1'b0);
    run_txn(7'd33, a_alt, w_alt, 0, 0, 1'b0);
    run_txn(7'd32, a_alt, w_alt, 3, 5, 1'b0);

    // Reset after two accepted words must discard the partial sum.
    START = 1'b1; THRESH = 7'd10;
    @(negedge CLK);
    START = 1'b0;
    send_word(16'hFFFF, 16'hFFFF);
    send_word(16'hFFFF, 16'hFFFF);
    RST = 1'b1;
    #1;
    check("mid_rst_in_ready", IN_READY, 0);
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_out_sum", OUT_SUM, 0);
    check("mid_rst_out_bit", OUT_BIT, 0);
    check("mid_rst_busy", BUSY, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      seen |= OUT_VALID | BUSY;
    end
    check("no_activity_after_rst", seen, 0);
    run_txn(7'd32, ones, ones, 0, 0, 1'b0);

    // START pulses in ACCUM and DONE must not restart or relatch THRESH.
    run_txn(7'd33, a_alt, w_alt, 1, 3, 1'b1);

    for (int t = 0; t < 4; t++) begin
      logic [NWORDS*WIDTH-1:0] ra, rw;
      for (int k = 0; k < NWORDS; k++) begin
        ra[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        rw[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      run_txn(ACC_W'($urandom_range(20, 44)), ra, rw,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/xnor_popcount_neuron.md
XNOR_POPCOUNT_NEURON -- requirements
Module: xnor_popcount_neuron

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the activation/weight word width in bits.
REQ-002 SHALL have parameter NWORDS, default 4, giving the number of words per dot product.
REQ-003 SHALL have parameter ACC_W, default clog2(WIDTH*NWORDS+1) = 7, giving the accumulator and threshold width (unsigned).
REQ-004 SHALL have port CLK, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port START, input, 1, single-cycle request to begin a new dot product.
REQ-007 SHALL have port IN_VALID, input, 1, activation/weight word pair valid.
REQ-008 SHALL have port IN_READY, output, 1, block accepts a word pair this cycle.
REQ-009 SHALL have port IN_ACT, input, WIDTH, parallel activation word from the serial-to-parallel deserializer.
REQ-010 SHALL have port IN_W, input, WIDTH, binary weight word.
REQ-011 SHALL have port THRESH, input, ACC_W, firing threshold; sampled on the START handshake.
REQ-012 SHALL have port OUT_VALID, output, 1, result valid.
REQ-013 SHALL have port OUT_READY, input, 1, consumer accepts the result.
REQ-014 SHALL have port OUT_SUM, output, ACC_W, total XNOR-popcount.
REQ-015 SHALL have port OUT_BIT, output, 1, binarized activation: 1 iff OUT_SUM >= THRESH.
REQ-016 SHALL have port BUSY, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ACCUM and DONE.
REQ-018 In IDLE, START=1 SHALL clear the accumulator and word counter, latch THRESH and move to ACCUM.
REQ-019 START SHALL be ignored in ACCUM and DONE.
REQ-020 IN_READY SHALL be 1 only in ACCUM, so a word pair is accepted only on a cycle with IN_VALID=1 and IN_READY=1.
REQ-021 Each accepted pair SHALL add popcount(~(IN_ACT ^ IN_W)) (range 0..WIDTH) to the accumulator in the same edge.
REQ-022 IN_VALID=0 cycles (gaps) SHALL leave the accumulator and counter unchanged.
REQ-023 The word counter SHALL count 0..NWORDS-1; on acceptance of word NWORDS-1 the state SHALL move to DONE and the counter SHALL return to 0.
REQ-024 In DONE, OUT_VALID SHALL be 1 and OUT_SUM/OUT_BIT SHALL be stable until OUT_READY=1.
REQ-025 The OUT_VALID && OUT_READY handshake SHALL return the state to IDLE on the next edge.
REQ-026 Latency from the last accepted word to OUT_VALID=1 SHALL be 1 cycle.
REQ-027 The accumulator SHALL never overflow: its maximum value is WIDTH*NWORDS, which fits in ACC_W bits.
REQ-028 OUT_BIT SHALL be computed as an unsigned ACC_W-bit comparison against the latched threshold.

Reset
REQ-029 RST=1 SHALL asynchronously force the state to IDLE and clear the accumulator, counter and latched threshold.
REQ-030 While RST=1, the outputs SHALL be IN_READY=0, OUT_VALID=0, OUT_SUM=0, OUT_BIT=0 and BUSY=0.
REQ-031 RST asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result; no OUT_VALID pulse SHALL follow.

Configuration
REQ-032 Macro POPCOUNT_PIPE_EN, when defined, SHALL insert a register between the XNOR-popcount and the accumulator adder.
REQ-033 With POPCOUNT_PIPE_EN defined, last-word-to-OUT_VALID latency SHALL be 2 cycles and DONE SHALL be entered only after the final staged popcount has been added.
REQ-034 With POPCOUNT_PIPE_EN defined, the pipeline register SHALL be cleared by RST.
REQ-035 Without POPCOUNT_PIPE_EN, the block SHALL behave exactly as REQ-021 to REQ-026.

Structure
REQ-036 The state encoding (IDLE/ACCUM/DONE) and the default WIDTH/NWORDS constants SHALL live in shared package bnn_pkg.
REQ-037 The popcount SHALL be a sub-module bnn_popcount (parameter WIDTH, purely combinational adder tree, output width clog2(WIDTH+1)).

Verification
REQ-038 4 pairs of IN_ACT=IN_W=16'hFFFF, THRESH=32 -> OUT_SUM=64, OUT_BIT=1, OUT_VALID 1 cycle after the 4th word (2 cycles with POPCOUNT_PIPE_EN).
REQ-039 IN_ACT=16'h0F0F, IN_W=16'hF0F0 for 4 words, THRESH=1 -> OUT_SUM=0, OUT_BIT=0.
REQ-040 2 words of 16'hAAAA/16'hAAAA plus 2 words of 16'h5555/16'hAAAA -> OUT_SUM=32; with THRESH=32 -> OUT_BIT=1; repeated with THRESH=33 -> OUT_BIT=0.
REQ-041 IN_VALID gaps of 3 idle cycles between words plus OUT_READY held low for 5 cycles -> same OUT_SUM, with OUT_VALID/OUT_SUM held constant throughout the stall.
REQ-042 RST pulsed after 2 accepted words -> all outputs 0 and state IDLE; a fresh START followed by 4 words of 16'hFFFF/16'hFFFF -> OUT_SUM=64 (no carry-over).
REQ-043 START pulsed during ACCUM and during DONE -> ignored, with the result and THRESH unchanged.
